// File: rtl/fnd_display_scheduler.sv
// Time-shares the 4-digit FND count_data input between three latched sources:
// dwell-based round robin, update-driven override and manual advance.
module fnd_display_scheduler #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned HOLD_MS = 2000,
    parameter int unsigned OVR_MS  = 3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] src0_data,
    input  logic        src0_upd,
    input  logic [13:0] src1_data,
    input  logic        src1_upd,
    input  logic [13:0] src2_data,
    input  logic        src2_upd,
    input  logic [2:0]  src_en,
    input  logic        auto_en,
    input  logic        btn_next,
    output logic [13:0] count_data,
    output logic [1:0]  cur_src,
    output logic        ovr_active,
    output logic        switch_pulse
);

    localparam int unsigned PRESC_TC = CLK_HZ / 1000;
    localparam int unsigned PW       = $clog2(PRESC_TC + 1);
    localparam int unsigned DMAX     = (HOLD_MS > OVR_MS) ? HOLD_MS : OVR_MS;
    localparam int unsigned DW       = $clog2(DMAX + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_TC - 1);
    localparam logic [DW-1:0] HOLD_LAST  = DW'(HOLD_MS - 1);
    localparam logic [DW-1:0] OVR_LAST   = DW'(OVR_MS - 1);
    localparam logic [13:0]   MAX_DISP   = 14'd9999;

    typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_OVR} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_cur_src, w_cur_nxt, w_next, w_lowest, w_ovr_src;
    logic [13:0]   r_latch0, r_latch1, r_latch2, r_count_data, w_disp;
    logic [PW-1:0] r_presc;
    logic [DW-1:0] r_dwell;
    logic          r_switch_pulse, w_tick, w_tmr_clr, w_ovr_hit;
    logic [2:0]    w_upd_en;

    // Next enabled index after i with wrap; i itself if it is the only one left.
    function automatic logic [1:0] f_next(input logic [1:0] i, input logic [2:0] en);
        logic [1:0] c1, c2, r;
        c1 = (i == 2'd2) ? 2'd0 : i + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (en[c1])      r = c1;
        else if (en[c2]) r = c2;
        else             r = i;
        return r;
    endfunction

    assign w_tick   = (r_presc == PRESC_LAST);
    assign w_next   = f_next(r_cur_src, src_en);
    assign w_lowest = src_en[0] ? 2'd0 : (src_en[1] ? 2'd1 : 2'd2);
    assign w_upd_en = {src2_upd, src1_upd, src0_upd} & src_en;

    always_comb begin
        w_ovr_hit = 1'b0;
        w_ovr_src = r_cur_src;
        for (int unsigned j = 0; j < 3; j++) begin
            if (!w_ovr_hit && w_upd_en[j] && (2'(j) != r_cur_src)) begin
                w_ovr_hit = 1'b1;
                w_ovr_src = 2'(j);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur_src;
        w_tmr_clr   = 1'b0;
        if (src_en == 3'b000) begin
            w_state_nxt = ST_IDLE;
            w_cur_nxt   = 2'd0;
            w_tmr_clr   = 1'b1;
        end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_SHOW;
            w_cur_nxt   = w_lowest;
            w_tmr_clr   = 1'b1;
        end else if (!src_en[r_cur_src]) begin
            w_state_nxt = ST_SHOW;
            w_cur_nxt   = w_next;
            w_tmr_clr   = 1'b1;
        end else if (w_ovr_hit) begin
            w_state_nxt = ST_OVR;
            w_cur_nxt   = w_ovr_src;
            w_tmr_clr   = 1'b1;
        end else if (btn_next) begin
            w_state_nxt = ST_SHOW;
            w_cur_nxt   = w_next;
            w_tmr_clr   = 1'b1;
        end else if (r_state == ST_SHOW && auto_en && w_tick && r_dwell == HOLD_LAST) begin
            w_cur_nxt = w_next;
            w_tmr_clr = 1'b1;
        end else if (r_state == ST_OVR && w_tick && r_dwell == OVR_LAST) begin
            w_state_nxt = ST_SHOW;
            w_tmr_clr   = 1'b1;
        end
    end

    always_comb begin
        case (r_cur_src)
            2'd1:    w_disp = r_latch1;
            2'd2:    w_disp = r_latch2;
            default: w_disp = r_latch0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cur_src      <= 2'd0;
            r_switch_pulse <= 1'b0;
            r_count_data   <= '0;
            r_latch0       <= '0;
            r_latch1       <= '0;
            r_latch2       <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cur_src      <= w_cur_nxt;
            r_switch_pulse <= (w_cur_nxt != r_cur_src);
            if (src0_upd) r_latch0 <= src0_data;
            if (src1_upd) r_latch1 <= src1_data;
            if (src2_upd) r_latch2 <= src2_data;
            if (r_state == ST_IDLE)      r_count_data <= '0;
            else if (w_disp > MAX_DISP)  r_count_data <= MAX_DISP;
            else                         r_count_data <= w_disp;
        end
    end

    // Dwell only accumulates in SHOW while rotation is enabled, or in OVR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_dwell <= '0;
        end else if (w_tmr_clr || r_state == ST_IDLE) begin
            r_presc <= '0;
            r_dwell <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (r_state == ST_SHOW && !auto_en) r_dwell <= '0;
            else if (w_tick)                    r_dwell <= r_dwell + 1'b1;
        end
    end

    assign count_data   = r_count_data;
    assign cur_src      = r_cur_src;
    assign ovr_active   = (r_state == ST_OVR);
    assign switch_pulse = r_switch_pulse;

endmodule
